// File: rtl/jetpack_game_seq.sv
// Frame-rate game sequencer: derives a per-frame tick from VGA vertical sync,
// runs the IDLE/PLAY/DEAD game FSM, integrates player motion and keeps score.
module jetpack_game_seq #(
    parameter int unsigned SCREEN_H    = 480,
    parameter int unsigned PLAYER_SIZE = 32,
    parameter int unsigned GRAVITY     = 1,
    parameter int unsigned THRUST      = 2,
    parameter int unsigned VMAX        = 8,
    parameter int unsigned DEAD_FRAMES = 120,
    parameter int unsigned SCORE_MAX   = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        VS,
    input  logic        thrust,
    input  logic        start,
    input  logic        collide,
    output logic        frame_tick,
    output logic [1:0]  game_state,
    output logic [9:0]  player_y,
    output logic [13:0] score
);

    localparam int unsigned YW = 10;
    localparam int unsigned SW = 14;
    localparam int unsigned VW = 5;
    localparam int unsigned EW = 7;
    localparam int unsigned AW = 11;
    localparam int unsigned CW = ($clog2(DEAD_FRAMES) > 7) ? $clog2(DEAD_FRAMES) : 7;

    localparam logic [YW-1:0]        Y_HOME  = YW'(SCREEN_H / 2 - PLAYER_SIZE / 2);
    localparam logic signed [AW-1:0] Y_FLOOR = AW'(SCREEN_H - PLAYER_SIZE);
    localparam logic signed [EW-1:0] GRV     = EW'(GRAVITY);
    localparam logic signed [EW-1:0] THR     = EW'(THRUST);
    localparam logic signed [EW-1:0] VLIM    = EW'(VMAX);
    localparam logic [SW-1:0]        S_MAX   = SW'(SCORE_MAX);
    localparam logic [CW-1:0]        D_LAST  = CW'(DEAD_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_DEAD = 2'b10
    } state_t;

    state_t               state, state_n;
    logic                 vs_q;
    logic signed [VW-1:0] vel, vel_n;
    logic [YW-1:0]        y_n;
    logic [SW-1:0]        score_n;
    logic [CW-1:0]        dead_cnt, cnt_n;

    logic signed [EW-1:0] vel_w, vel_dn, vel_up, vel_c;
    logic signed [AW-1:0] y_sum;

    assign game_state = state;

    // Candidate velocity (clamped to +/-VMAX) and unclamped next position.
    always_comb begin
        vel_w  = {{(EW - VW){vel[VW-1]}}, vel};
        vel_dn = vel_w + GRV;
        vel_up = vel_w - THR;
        if (thrust) begin
            vel_c = (vel_up < -VLIM) ? -VLIM : vel_up;
        end else begin
            vel_c = (vel_dn > VLIM) ? VLIM : vel_dn;
        end
        y_sum = $signed({1'b0, player_y}) + {{(AW - EW){vel_c[EW-1]}}, vel_c};
    end

    // Game FSM next-state and datapath updates.
    always_comb begin
        state_n = state;
        y_n     = player_y;
        vel_n   = vel;
        score_n = score;
        cnt_n   = dead_cnt;
        case (state)
            S_IDLE: begin
                y_n   = Y_HOME;
                vel_n = '0;
                if (start) begin
                    state_n = S_PLAY;
                    score_n = '0;
                end
            end
            S_PLAY: begin
                if (collide) begin
                    state_n = S_DEAD;
                    cnt_n   = '0;
                end else if (frame_tick) begin
                    if (y_sum < 11'sd0) begin
                        y_n   = '0;
                        vel_n = '0;
                    end else if (y_sum > Y_FLOOR) begin
                        y_n   = Y_FLOOR[YW-1:0];
                        vel_n = '0;
                    end else begin
                        y_n   = y_sum[YW-1:0];
                        vel_n = vel_c[VW-1:0];
                    end
                    score_n = (score >= S_MAX) ? S_MAX : score + SW'(1);
                end
            end
            S_DEAD: begin
                if (frame_tick) begin
                    if (dead_cnt == D_LAST) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = dead_cnt + CW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q       <= 1'b1;
            frame_tick <= 1'b0;
            state      <= S_IDLE;
            player_y   <= Y_HOME;
            vel        <= '0;
            score      <= '0;
            dead_cnt   <= '0;
        end else begin
            vs_q       <= VS;
            frame_tick <= vs_q & ~VS;
            state      <= state_n;
            player_y   <= y_n;
            vel        <= vel_n;
            score      <= score_n;
            dead_cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_jetpack_game_seq.sv
// Scoreboard bench for jetpack_game_seq: each frame pushes its expected
// post-tick state; a negedge monitor compares one cycle after every tick.
module tb_jetpack_game_seq;

    logic        clk;
    logic        rst;
    logic        VS;
    logic        thrust;
    logic        start;
    logic        collide;
    logic        frame_tick;
    logic [1:0]  game_state;
    logic [9:0]  player_y;
    logic [13:0] score;

    typedef struct {
        logic [1:0] st;
        int         y;
        int         sc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_frame = 0;
    logic pend = 1'b0;

    jetpack_game_seq dut (
        .clk        (clk),
        .rst        (rst),
        .VS         (VS),
        .thrust     (thrust),
        .start      (start),
        .collide    (collide),
        .frame_tick (frame_tick),
        .game_state (game_state),
        .player_y   (player_y),
        .score      (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: the cycle after each frame_tick, pop one expectation.
    always @(negedge clk) begin
        if (pend && !rst) begin
            n_vec = n_vec + 1;
            n_frame = n_frame + 1;
            if (sb_q.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_tick #%0d: state=%0d y=%0d score=%0d, no tick expected",
                         n_frame, game_state, player_y, score);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (game_state !== e.st || player_y !== 10'(e.y) || score !== 14'(e.sc)) begin
                    n_err = n_err + 1;
                    $display("FAIL frame #%0d: got state=%0d y=%0d score=%0d, expected state=%0d y=%0d score=%0d",
                             n_frame, game_state, player_y, score, e.st, e.y, e.sc);
                end
            end
        end
        pend <= frame_tick;
    end

    task automatic chk(input string name, input logic [1:0] st, input int y, input int sc);
        n_vec = n_vec + 1;
        if (game_state !== st || player_y !== 10'(y) || score !== 14'(sc)) begin
            n_err = n_err + 1;
            $display("FAIL %s: got state=%0d y=%0d score=%0d, expected state=%0d y=%0d score=%0d",
                     name, game_state, player_y, score, st, y, sc);
        end
    endtask

    // One VS frame: low for lo cycles then high for hi cycles (hi >= 1).
    // collide, if requested, is raised on the cycle frame_tick is high.
    task automatic frame(input int lo, input int hi, input bit col,
                         input logic [1:0] st, input int y, input int sc);
        sb_q.push_back('{st, y, sc});
        VS = 1'b0;
        for (int i = 0; i < lo + hi; i++) begin
            @(posedge clk); #1;
            collide = col && (i == 0);
            VS = (i + 1 >= lo);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_to_play", 2'b01, 224, 0);
    endtask

    function automatic int grav_y(input int n);
        int v;
        case (n)
            1: v = 225;
            2: v = 227;
            3: v = 230;
            4: v = 234;
            5: v = 239;
            6: v = 245;
            7: v = 252;
            default: begin
                v = 260 + 8 * (n - 8);
                if (v > 448) v = 448;
            end
        endcase
        return v;
    endfunction

    function automatic int thr_y(input int n);
        int v;
        case (n)
            1: v = 222;
            2: v = 218;
            3: v = 212;
            4: v = 204;
            default: begin
                v = 196 - 8 * (n - 5);
                if (v < 0) v = 0;
            end
        endcase
        return v;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; VS = 1'b1; thrust = 1'b0; start = 1'b0; collide = 1'b0;
        #2;
        chk("reset_values", 2'b00, 224, 0);
        n_vec = n_vec + 1;
        if (frame_tick !== 1'b0) begin
            n_err = n_err + 1;
            $display("FAIL reset_tick: got %0b expected 0", frame_tick);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Gravity from home up to y = 300, then asynchronous reset mid-PLAY.
        do_start();
        for (int n = 1; n <= 13; n++) frame(1, 2, 1'b0, 2'b01, grav_y(n), n);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_reset_midplay", 2'b00, 224, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Idle frames without start.
        for (int n = 1; n <= 3; n++) frame(1, 2, 1'b0, 2'b00, 224, 0);

        // Thrust up to the ceiling.
        do_start();
        thrust = 1'b1;
        for (int n = 1; n <= 32; n++) frame(1, 2, 1'b0, 2'b01, thr_y(n), n);
        thrust = 1'b0;

        // Collision coincident with tick, then exactly 120 DEAD ticks.
        frame(1, 2, 1'b1, 2'b10, 0, 32);
        start = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            if (n == 6) start = 1'b0;
            frame(1, 2, 1'b0, (n == 120) ? 2'b00 : 2'b10, 0, 32);
        end
        frame(1, 2, 1'b0, 2'b00, 224, 32);

        // Full gravity run to the floor, then on to score saturation.
        do_start();
        for (int n = 1; n <= 10001; n++)
            frame(1, 2, 1'b0, 2'b01, grav_y(n), (n > 9999) ? 9999 : n);

        collide = 1'b1;
        @(posedge clk); #1;
        collide = 1'b0;
        chk("collide_no_tick", 2'b10, 448, 9999);
        for (int n = 1; n <= 120; n++)
            frame(1, 2, 1'b0, (n == 120) ? 2'b00 : 2'b10, 448, 9999);
        do_start();

        // Tick generation: long low, short low, then VS held high.
        frame(20, 2, 1'b0, 2'b01, 225, 1);
        frame(1, 2, 1'b0, 2'b01, 227, 2);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
        end

        n_vec = n_vec + 1;
        if (sb_q.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL missing_ticks: %0d expectations left, expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
